// File: rtl/pipe_wb_regfile_pkg.sv
// pipe_wb_regfile_pkg
//   Shared sizing constants for the write-back stage register file.
//   NREGS   : number of architectural registers (r0 is hard-wired to zero)
//   XLEN    : data width
//   RADDR_W : register address width
//   ZERO_REG: index of the hard-wired zero register
package pipe_wb_regfile_pkg;

    localparam int NREGS   = 32;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [RADDR_W-1:0] ZERO_REG = '0;

    // A write-back only takes effect when enabled and aimed at a real register.
    function automatic logic wb_active(input logic wreg, input logic [RADDR_W-1:0] rn);
        return wreg && (rn != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w
//   Register storage: one write port, two pipeline read ports and one debug
//   read port. Reads are combinational and return stored contents only.
//   Ports:
//     clk, rst         : clock, asynchronous active-low reset (clears r1..r31)
//     we, waddr, wdata : write port, sampled on the rising edge
//     ra_a/ra_b/ra_d   : read addresses for port A, port B and debug
//     qa/qb/qd         : read data (r0 always reads zero)
module regfile_2r1w
    import pipe_wb_regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic [RADDR_W-1:0] ra_a,
    input  logic [RADDR_W-1:0] ra_b,
    input  logic [RADDR_W-1:0] ra_d,
    output logic [XLEN-1:0]    qa,
    output logic [XLEN-1:0]    qb,
    output logic [XLEN-1:0]    qd
);

    // r0 has no storage; its reads are decoded to zero.
    logic [XLEN-1:0] regs [1:NREGS-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != ZERO_REG)) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [XLEN-1:0] rd(input logic [RADDR_W-1:0] a);
        return (a == ZERO_REG) ? '0 : regs[a];
    endfunction

    assign qa = rd(ra_a);
    assign qb = rd(ra_b);
    assign qd = rd(ra_d);

endmodule

// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile
//   Write-back stage plus register file. Selects the write-back value,
//   commits it to the register file, bypasses it onto the decode-stage read
//   ports when the addresses match, and counts committed writes.
//   Ports:
//     clk, rst             : clock, asynchronous active-low reset
//     i_wreg, i_m2reg      : write enable, result select (1 = memory data)
//     i_mo, i_alu, i_rn    : memory data, ALU result, destination register
//     i_rs, i_rt           : decode read addresses for ports A and B
//     o_qa, o_qb           : read data with write-back bypass
//     o_wdata              : selected write-back value (for forwarding)
//     i_dbg_rn, o_dbg_q    : debug read, stored contents only
//     o_wbcnt              : number of committed register writes (wraps)
module pipe_wb_regfile
    import pipe_wb_regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wreg,
    input  logic               i_m2reg,
    input  logic [XLEN-1:0]    i_mo,
    input  logic [XLEN-1:0]    i_alu,
    input  logic [RADDR_W-1:0] i_rn,
    input  logic [RADDR_W-1:0] i_rs,
    input  logic [RADDR_W-1:0] i_rt,
    output logic [XLEN-1:0]    o_qa,
    output logic [XLEN-1:0]    o_qb,
    output logic [XLEN-1:0]    o_wdata,
    input  logic [RADDR_W-1:0] i_dbg_rn,
    output logic [XLEN-1:0]    o_dbg_q,
    output logic [XLEN-1:0]    o_wbcnt
);

    logic            commit;
    logic [XLEN-1:0] stored_a;
    logic [XLEN-1:0] stored_b;
    logic [XLEN-1:0] wbcnt_q;

    assign o_wdata = i_m2reg ? i_mo : i_alu;
    assign commit  = wb_active(i_wreg, i_rn);

    regfile_2r1w u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (commit),
        .waddr (i_rn),
        .wdata (o_wdata),
        .ra_a  (i_rs),
        .ra_b  (i_rt),
        .ra_d  (i_dbg_rn),
        .qa    (stored_a),
        .qb    (stored_b),
        .qd    (o_dbg_q)
    );

    // Write-then-read in the same cycle: the decode stage sees the value
    // being written now. Deliberately not gated by rst, so forwarding stays
    // live from the inputs even while storage is held in reset.
    assign o_qa = (commit && (i_rn == i_rs)) ? o_wdata : stored_a;
    assign o_qb = (commit && (i_rn == i_rt)) ? o_wdata : stored_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbcnt_q <= '0;
        end else if (commit) begin
            wbcnt_q <= wbcnt_q + 1'b1;
        end
    end

    assign o_wbcnt = wbcnt_q;

endmodule

// File: doc/pipe_wb_regfile.md
PIPE_WB_REGFILE -- requirements
Module: pipe_wb_regfile

Interface
REQ-001 SHALL: clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL: rst, input, 1, reset, asynchronous and active-low (asserted when 0).
REQ-003 SHALL: i_wreg, input, 1, write-back enable from the MEM/WB register.
REQ-004 SHALL: i_m2reg, input, 1, result select (1 = memory data, 0 = ALU result).
REQ-005 SHALL: i_mo, input, 32, memory output data from the MEM/WB register.
REQ-006 SHALL: i_alu, input, 32, ALU result from the MEM/WB register.
REQ-007 SHALL: i_rn, input, 5, destination register number.
REQ-008 SHALL: i_rs / i_rt, input, 5 each, decode-stage read addresses for ports A and B.
REQ-009 SHALL: o_qa / o_qb, output, 32 each, read data for ports A and B.
REQ-010 SHALL: o_wdata, output, 32, selected write-back value, exported for forwarding.
REQ-011 SHALL: i_dbg_rn, input, 5, debug read address.
REQ-012 SHALL: o_dbg_q, output, 32, debug read data, without bypass.
REQ-013 SHALL: o_wbcnt, output, 32, count of committed register writes.

Function
REQ-014 SHALL: o_wdata = i_m2reg ? i_mo : i_alu, combinational, zero latency.
REQ-015 SHALL: commit o_wdata into register i_rn on the rising edge when i_wreg=1, i_rn!=0 and rst=1.
REQ-016 SHALL: register 0 reads 0 on all ports; writes to it are discarded.
REQ-017 SHALL: reads are combinational from i_rs / i_rt / i_dbg_rn.
REQ-018 SHALL: bypass on ports A/B: if i_wreg=1, i_rn!=0 and i_rn equals the read address, output o_wdata instead of the stored value (write-then-read in the same cycle).
REQ-019 SHALL: bypass applies independently to A and B; when i_rs=i_rt, both ports are bypassed.
REQ-020 SHALL: o_dbg_q returns stored contents only (no bypass).
REQ-021 SHALL: o_wbcnt increments by 1 per committed write (REQ-015 conditions only), wrapping from 0xFFFFFFFF to 0.
REQ-022 SHALL: i_wreg=0 leaves all registers and o_wbcnt unchanged, regardless of i_m2reg/i_rn.

Reset
REQ-023 SHALL: on rst=0, registers 1..31 and o_wbcnt clear immediately (asynchronously) to 0.
REQ-024 SHALL: no write or count occurs on any edge while rst=0, including a write pending at assertion.
REQ-025 SHALL: during reset, o_qa/o_qb still obey REQ-018 bypass from live inputs; stored values read 0.
REQ-026 SHALL: first write is possible on the first rising edge with rst=1.

Structure
REQ-027 SHALL: shared package holds NREGS=32, XLEN=32, RADDR_W=5 and the zero-register index constant.
REQ-028 SHALL: the storage array is one sub-module, regfile_2r1w (3 read ports incl. debug, 1 write); bypass, write-back mux and counter stay in the top.
REQ-029 SHALL: no latches; storage uses the asynchronous-reset flop style with the rst polarity above.

Verification
REQ-030 SHALL: reset, then write i_alu=0x12345678 to r5 (i_m2reg=0) -> next cycle with i_rs=5: o_qa=0x12345678, o_wbcnt=1.
REQ-031 SHALL: i_m2reg=1, i_mo=0xDEADBEEF, i_rn=7, i_rt=7 in the same cycle -> o_qb=0xDEADBEEF before the edge (bypass), o_dbg_q(7) old value until the edge, then 0xDEADBEEF.
REQ-032 SHALL: i_wreg=1, i_rn=0, i_alu=0xFFFFFFFF -> o_qa(rs=0)=0 in the same and next cycle, o_wbcnt unchanged.
REQ-033 SHALL: drop rst mid-stream with i_wreg=1 to r9 -> r9 stays 0, o_wbcnt=0; after release, first write counts as 1.
REQ-034 SHALL: preload o_wbcnt to 0xFFFFFFFF via repeated writes (or force), one more commit -> o_wbcnt=0.
